vga_scan_timer: RTL

Free-running 640x480@60 VGA scan generator for the DE-series video path. It produces the 25 MHz pixel clock, the horizontal and vertical scan counters, the sync and blank outputs, and per-line, per-frame and once-per-second strobes. It sits directly upstream of the sprite/pixel colour stage. That stage consumes `hor_counter`/`ver_counter` and `bg_state`, and drives `RGB` in the same pixel slot.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_scan_timer_if.sv | 32 +++
 rtl/scan_counter.sv | 38 +++
 rtl/vga_scan_timer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and the background-state type shared
// by the scan timer and the downstream colour stage.
package vga_pkg;

   localparam int H_ACTIVE     = 640;
   localparam int H_SYNC_START = 656;
   localparam int H_SYNC_END   = 751;
   localparam int H_TOTAL      = 800;
   localparam int V_ACTIVE     = 480;
   localparam int V_SYNC_START = 490;
   localparam int V_SYNC_END   = 491;
   localparam int V_TOTAL      = 525;
   localparam int SEC_CYCLES   = 50_000_000;
   localparam int BG_STATES    = 3;

   typedef enum logic [1:0] {
      BG_0 = 2'd0,
      BG_1 = 2'd1,
      BG_2 = 2'd2
   } bg_state_t;

endpackage

// File: rtl/vga_scan_timer_if.sv
// vga_scan_timer_if: scan outputs of the timer as seen by the colour stage.
// The timer drives everything (master); consumers only read (slave).
interface vga_scan_timer_if;
   import vga_pkg::*;

   logic       VGA_CLK;
   logic       VGA_HS;
   logic       VGA_VS;
   logic       VGA_BLANK_N;
   logic       VGA_SYNC_N;
   logic [9:0] hor_counter;
   logic [9:0] ver_counter;
   logic       pix_en;
   logic       line_start;
   logic       frame_start;
   logic [7:0] frame_count;
   logic       sec_tick;
   bg_state_t  bg_state;

   modport master (
      output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
      output hor_counter, ver_counter, pix_en, line_start, frame_start,
      output frame_count, sec_tick, bg_state
   );

   modport slave (
      input VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
      input hor_counter, ver_counter, pix_en, line_start, frame_start,
      input frame_count, sec_tick, bg_state
   );

endinterface

// File: rtl/scan_counter.sv
// scan_counter: enabled wrap counter 0..MAX. Exposes the registered count,
// the value it will take at the next edge, and a wrap flag that is high in
// the cycle the count returns to 0.
module scan_counter #(
   parameter int W   = 10,
   parameter int MAX = 799
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic [W-1:0] nxt_o,
   output logic         wrap_o
);

   localparam logic [W-1:0] LAST = W'(MAX);

   logic [W-1:0] cnt_q, cnt_d;

   // next count: hold, increment, or wrap to zero at LAST
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
      end
   end

   // count register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign nxt_o  = cnt_d;
   assign wrap_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/vga_scan_timer.sv
// vga_scan_timer: free-running VGA scan generator. Produces the /2 pixel
// clock, H/V scan counters, sync/blank, line/frame strobes, a frame counter
// and a once-per-second tick that steps the background colour index.
module vga_scan_timer #(
   parameter int H_ACTIVE     = vga_pkg::H_ACTIVE,
   parameter int H_SYNC_START = vga_pkg::H_SYNC_START,
   parameter int H_SYNC_END   = vga_pkg::H_SYNC_END,
   parameter int H_TOTAL      = vga_pkg::H_TOTAL,
   parameter int V_ACTIVE     = vga_pkg::V_ACTIVE,
   parameter int V_SYNC_START = vga_pkg::V_SYNC_START,
   parameter int V_SYNC_END   = vga_pkg::V_SYNC_END,
   parameter int V_TOTAL      = vga_pkg::V_TOTAL,
   parameter int SEC_CYCLES   = vga_pkg::SEC_CYCLES,
   parameter int BG_STATES    = vga_pkg::BG_STATES
) (
   input  logic             Clk_50MHz,
   input  logic             Rst_n,
   vga_scan_timer_if.master vga
);

   localparam int         SEC_W = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
   localparam logic [9:0] HA    = 10'(H_ACTIVE);
   localparam logic [9:0] HSS   = 10'(H_SYNC_START);
   localparam logic [9:0] HSE   = 10'(H_SYNC_END);
   localparam logic [9:0] VA    = 10'(V_ACTIVE);
   localparam logic [9:0] VSS   = 10'(V_SYNC_START);
   localparam logic [9:0] VSE   = 10'(V_SYNC_END);

   if (H_SYNC_END >= H_TOTAL) begin : g_bad_h
      $error("vga_scan_timer: H_SYNC_END must be below H_TOTAL");
   end
   if (V_SYNC_END >= V_TOTAL) begin : g_bad_v
      $error("vga_scan_timer: V_SYNC_END must be below V_TOTAL");
   end

   logic             vga_clk_q;
   logic [9:0]       h_cnt, h_nxt, v_cnt, v_nxt;
   logic             h_wrap, v_wrap;
   logic [SEC_W-1:0] sec_cnt, sec_nxt;
   logic             sec_wrap;
   logic [1:0]       bg_cnt, bg_nxt;
   logic             bg_wrap;
   logic             hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
   logic             line_q, frame_q, tick_q;
   logic [7:0]       fcnt_q, fcnt_d;
   logic             unused_sig;

   // pixel clock: toggles every system cycle; its high phase is the advance slot
   always_ff @(posedge Clk_50MHz or negedge Rst_n) begin
      if (!Rst_n) vga_clk_q <= 1'b0;
      else        vga_clk_q <= ~vga_clk_q;
   end

   scan_counter #(.W(10), .MAX(H_TOTAL - 1)) u_hor (
      .clk_i(Clk_50MHz), .rst_n_i(Rst_n), .en_i(vga_clk_q),
      .cnt_o(h_cnt), .nxt_o(h_nxt), .wrap_o(h_wrap)
   );

   scan_counter #(.W(10), .MAX(V_TOTAL - 1)) u_ver (
      .clk_i(Clk_50MHz), .rst_n_i(Rst_n), .en_i(h_wrap),
      .cnt_o(v_cnt), .nxt_o(v_nxt), .wrap_o(v_wrap)
   );

   scan_counter #(.W(SEC_W), .MAX(SEC_CYCLES - 1)) u_sec (
      .clk_i(Clk_50MHz), .rst_n_i(Rst_n), .en_i(1'b1),
      .cnt_o(sec_cnt), .nxt_o(sec_nxt), .wrap_o(sec_wrap)
   );

   scan_counter #(.W(2), .MAX(BG_STATES - 1)) u_bg (
      .clk_i(Clk_50MHz), .rst_n_i(Rst_n), .en_i(sec_wrap),
      .cnt_o(bg_cnt), .nxt_o(bg_nxt), .wrap_o(bg_wrap)
   );

   // sync/blank decoded from the next counter values so they land with them
   always_comb begin
      hs_d    = ~((h_nxt >= HSS) && (h_nxt <= HSE));
      vs_d    = ~((v_nxt >= VSS) && (v_nxt <= VSE));
      blank_d = (h_nxt < HA) && (v_nxt < VA);
      fcnt_d  = fcnt_q + 8'(v_wrap);
   end

   // registered sync, blank, strobes and frame count
   always_ff @(posedge Clk_50MHz or negedge Rst_n) begin
      if (!Rst_n) begin
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         blank_q <= 1'b1;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
         tick_q  <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         blank_q <= blank_d;
         line_q  <= h_wrap;
         frame_q <= v_wrap;
         tick_q  <= sec_wrap;
         fcnt_q  <= fcnt_d;
      end
   end

   assign vga.VGA_CLK     = vga_clk_q;
   assign vga.pix_en      = vga_clk_q;
   assign vga.VGA_HS      = hs_q;
   assign vga.VGA_VS      = vs_q;
   assign vga.VGA_BLANK_N = blank_q;
   assign vga.VGA_SYNC_N  = 1'b0;
   assign vga.hor_counter = h_cnt;
   assign vga.ver_counter = v_cnt;
   assign vga.line_start  = line_q;
   assign vga.frame_start = frame_q;
   assign vga.frame_count = fcnt_q;
   assign vga.sec_tick    = tick_q;
   assign vga.bg_state    = vga_pkg::bg_state_t'(bg_cnt);

   // the second counter value and the bg next/wrap taps have no consumer here
   assign unused_sig = ^{sec_cnt, sec_nxt, bg_nxt, bg_wrap};

endmodule
